ctrl_fsm_alub: RTL and testbench
================================

CTRL_FSM_ALUB -- requirements
Module: ctrl_fsm_alub

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra memory-wait cycles per memory read (0..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  instr[31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instr[5:0] from the instruction register.
REQ-006 SHALL have port pc_write  output  1  unconditional PC load.
REQ-007 SHALL have port pc_write_cond  output  1  PC load qualified externally by ALU zero.
REQ-008 SHALL have port iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 SHALL have port mem_wr  output  1  memory write strobe.
REQ-010 SHALL have port ir_write  output  1  instruction register load.
REQ-011 SHALL have port reg_write, reg_dst, mem_to_reg  output  1 each  register file controls (reg_dst 1 = rd, 0 = rt; mem_to_reg 1 = MDR).
REQ-012 SHALL have port alu_src_a  output  1  0 = PC, 1 = A.
REQ-013 SHALL have port alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
REQ-014 SHALL have port alu_op  output  3  000 load A, 001 add, 010 sub, 011 and, 110 xor.
REQ-015 SHALL have port pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-016 SHALL have ports exc  output  1 (illegal-instruction pulse) and state_out  output  4 (current state code).

Function
REQ-017 SHALL be a Moore FSM; all outputs are decoded from the state register and wait counter only; any output not listed for a state is 0.
REQ-018 SHALL use state codes RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, R_WB=8, BRANCH=9, ADDI_EXEC=10, ADDI_WB=11, JUMP=12, EXCEPT=13; codes 14-15 return to FETCH on the next edge.
REQ-019 RESET: all outputs 0; next state FETCH.
REQ-020 FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=001, pc_source=00; held for MEM_WAIT+1 cycles by a 4-bit wait counter; ir_write=1 and pc_write=1 only in the final cycle; next state DECODE.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, alu_op=001; register funct internally; branch on opcode: 0x00 -> EXEC_R, 0x23/0x2B -> MEM_ADDR, 0x04 -> BRANCH, 0x08 -> ADDI_EXEC, 0x02 -> JUMP, other -> EXCEPT.
REQ-022 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=001; next state MEM_READ for 0x23, MEM_WRITE for 0x2B.
REQ-023 MEM_READ: iord=1; held MEM_WAIT+1 cycles; next state MEM_WB.
REQ-024 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; MEM_WRITE: iord=1, mem_wr=1 for exactly one cycle; both return to FETCH.
REQ-025 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from registered funct (0x20 -> 001, 0x22 -> 010, 0x24 -> 011, 0x26 -> 110); unsupported funct -> EXCEPT without any reg_write.
REQ-026 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_op held from EXEC_R; next state FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=010, pc_write_cond=1, pc_source=01; one cycle; next state FETCH.
REQ-028 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=001; ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-029 JUMP: pc_write=1, pc_source=10; one cycle; next state FETCH.
REQ-030 EXCEPT: exc=1 for exactly one cycle, no write strobes; next state FETCH.
REQ-031 Wait counter SHALL reset to 0 on entry to FETCH/MEM_READ and SHALL not wrap; MEM_WAIT=0 gives single-cycle FETCH/MEM_READ.
REQ-032 Cycle counts with MEM_WAIT=0: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.

Reset
REQ-033 reset asserted SHALL force state RESET, counter 0 and all outputs 0 immediately, independent of clk.
REQ-034 Reset mid-instruction SHALL abort it with no further write strobe; first FETCH occurs one cycle after deassertion.

Verification
REQ-035 Reset release, opcode=0x00 funct=0x20 -> states 0,1,2,7,8,1; reg_write=1 with reg_dst=1 only in R_WB.
REQ-036 MEM_WAIT=2, lw (0x23) -> FETCH lasts 3 cycles, ir_write/pc_write only in 3rd; MEM_READ lasts 3 cycles; reg_write with mem_to_reg=1 once.
REQ-037 beq (0x04) -> BRANCH shows alu_src_b=00, alu_op=010, pc_write_cond=1, pc_source=01 for one cycle; DECODE shows alu_src_b=11.
REQ-038 opcode=0x3F, then opcode=0x00 funct=0x2A -> each gives exc=1 for one cycle, no reg_write/mem_wr, back to FETCH.
REQ-039 sw (0x2B) with reset asserted during MEM_ADDR -> outputs 0 asynchronously, mem_wr never asserted, FETCH one cycle after release.
REQ-040 j (0x02) -> JUMP shows pc_write=1, pc_source=10; total 3 cycles FETCH-to-FETCH.

Source files
------------

// File: rtl/ctrl_fsm_alub.sv
// ctrl_fsm_alub: multi-cycle MIPS-subset control FSM with parameterised memory wait states
//   clk, reset (async, active-high), opcode/funct from the instruction register
//   out: pc_write, pc_write_cond, iord, mem_wr, ir_write, reg_write, reg_dst, mem_to_reg,
//        alu_src_a, alu_src_b, alu_op, pc_source, exc, state_out
module ctrl_fsm_alub #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       exc,
  output logic [3:0] state_out
);
  typedef enum logic [3:0] {
    RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    EXEC_R, R_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP, EXCEPT
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       exc;
  } ctl_t;
  localparam logic [3:0] LAST = 4'(MEM_WAIT);
  state_t     state, ns;
  logic [3:0] cnt, nc;
  logic [5:0] f_q, nf;
  ctl_t       q;
  // unsupported funct maps to 000, which EXEC_R uses to divert to EXCEPT
  function automatic logic [2:0] alu_f(logic [5:0] f);
    return f == 6'h20 ? 3'b001 : f == 6'h22 ? 3'b010 :
           f == 6'h24 ? 3'b011 : f == 6'h26 ? 3'b110 : 3'b000;
  endfunction
  function automatic ctl_t dec(state_t s, logic [3:0] c, logic [5:0] f);
    ctl_t d;
    d = '0;
    case (s)
      FETCH: begin
        d.alu_src_b = 2'b01;
        d.alu_op    = 3'b001;
        d.ir_write  = c == LAST;
        d.pc_write  = c == LAST;
      end
      DECODE:    begin d.alu_src_b = 2'b11; d.alu_op = 3'b001; end
      MEM_ADDR:  begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; d.alu_op = 3'b001; end
      MEM_READ:  d.iord = 1'b1;
      MEM_WB:    begin d.reg_write = 1'b1; d.mem_to_reg = 1'b1; end
      MEM_WRITE: begin d.iord = 1'b1; d.mem_wr = 1'b1; end
      EXEC_R:    begin d.alu_src_a = 1'b1; d.alu_op = alu_f(f); end
      R_WB:      begin d.reg_write = 1'b1; d.reg_dst = 1'b1; d.alu_op = alu_f(f); end
      BRANCH: begin
        d.alu_src_a     = 1'b1;
        d.alu_op        = 3'b010;
        d.pc_write_cond = 1'b1;
        d.pc_source     = 2'b01;
      end
      ADDI_EXEC: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; d.alu_op = 3'b001; end
      ADDI_WB:   d.reg_write = 1'b1;
      JUMP:      begin d.pc_write = 1'b1; d.pc_source = 2'b10; end
      EXCEPT:    d.exc = 1'b1;
      default:   ;
    endcase
    return d;
  endfunction
  always_comb begin
    ns = FETCH;
    case (state)
      FETCH:    ns = cnt == LAST ? DECODE : FETCH;
      DECODE:   ns = opcode == 6'h00 ? EXEC_R :
                     (opcode == 6'h23 || opcode == 6'h2B) ? MEM_ADDR :
                     opcode == 6'h04 ? BRANCH :
                     opcode == 6'h08 ? ADDI_EXEC :
                     opcode == 6'h02 ? JUMP : EXCEPT;
      MEM_ADDR: ns = opcode == 6'h23 ? MEM_READ : MEM_WRITE;
      MEM_READ: ns = cnt == LAST ? MEM_WB : MEM_READ;
      EXEC_R:   ns = alu_f(f_q) != 3'b000 ? R_WB : EXCEPT;
      ADDI_EXEC: ns = ADDI_WB;
      default:  ns = FETCH;
    endcase
    // counter restarts on every state entry and saturates while held
    nc = ns != state ? 4'd0 : (&cnt ? cnt : cnt + 4'd1);
    nf = state == DECODE ? funct : f_q;
  end
  // outputs are decoded from the next state so they are registered yet Moore-aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET;
      cnt   <= '0;
      f_q   <= '0;
      q     <= '0;
    end else begin
      state <= ns;
      cnt   <= nc;
      f_q   <= nf;
      q     <= dec(ns, nc, nf);
    end
  end
  assign {pc_write, pc_write_cond, iord, mem_wr, ir_write, reg_write, reg_dst,
          mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, exc} = q;
  assign state_out = state;
endmodule

// File: tb/tb_ctrl_fsm_alub.sv
// tb_ctrl_fsm_alub: table-driven check of ctrl_fsm_alub with MEM_WAIT=0 and MEM_WAIT=2
module tb_ctrl_fsm_alub;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  wire  [16:0] o0, o1;
  wire  [3:0]  s0, s1;
  int tests = 0;
  int fails = 0;
  int rw_cnt;
  logic mon = 1'b0;
  logic mw_seen = 1'b0;
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
    logic [16:0] o;
  } vec_t;
  vec_t tbl[$];
  vec_t tbl2[$];
  function automatic logic [16:0] mk(bit pcw, bit pcc, bit io, bit mw, bit irw, bit rw,
                                     bit rd, bit m2r, bit a, bit [1:0] b, bit [2:0] op,
                                     bit [1:0] ps, bit ex);
    return {pcw, pcc, io, mw, irw, rw, rd, m2r, a, b, op, ps, ex};
  endfunction
  function automatic logic [16:0] ex_r(bit [2:0] op);
    return mk(0,0,0,0,0,0,0,0,1,2'b00,op,2'b00,0);
  endfunction
  function automatic logic [16:0] r_wb(bit [2:0] op);
    return mk(0,0,0,0,0,1,1,0,0,2'b00,op,2'b00,0);
  endfunction
  localparam logic [16:0] Z   = 17'd0;
  localparam logic [16:0] F1  = mk(1,0,0,0,1,0,0,0,0,2'b01,3'b001,2'b00,0);
  localparam logic [16:0] F0  = mk(0,0,0,0,0,0,0,0,0,2'b01,3'b001,2'b00,0);
  localparam logic [16:0] DEC = mk(0,0,0,0,0,0,0,0,0,2'b11,3'b001,2'b00,0);
  localparam logic [16:0] MA  = mk(0,0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0);
  localparam logic [16:0] MR  = mk(0,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
  localparam logic [16:0] MWB = mk(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0);
  localparam logic [16:0] MWR = mk(0,0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0);
  localparam logic [16:0] BR  = mk(0,1,0,0,0,0,0,0,1,2'b00,3'b010,2'b01,0);
  localparam logic [16:0] AE  = mk(0,0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0);
  localparam logic [16:0] AW  = mk(0,0,0,0,0,1,0,0,0,2'b00,3'b000,2'b00,0);
  localparam logic [16:0] JP  = mk(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0);
  localparam logic [16:0] EXC = mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1);
  ctrl_fsm_alub #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .pc_write(o0[16]), .pc_write_cond(o0[15]), .iord(o0[14]), .mem_wr(o0[13]),
    .ir_write(o0[12]), .reg_write(o0[11]), .reg_dst(o0[10]), .mem_to_reg(o0[9]),
    .alu_src_a(o0[8]), .alu_src_b(o0[7:6]), .alu_op(o0[5:3]), .pc_source(o0[2:1]),
    .exc(o0[0]), .state_out(s0)
  );
  ctrl_fsm_alub #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .pc_write(o1[16]), .pc_write_cond(o1[15]), .iord(o1[14]), .mem_wr(o1[13]),
    .ir_write(o1[12]), .reg_write(o1[11]), .reg_dst(o1[10]), .mem_to_reg(o1[9]),
    .alu_src_a(o1[8]), .alu_src_b(o1[7:6]), .alu_op(o1[5:3]), .pc_source(o1[2:1]),
    .exc(o1[0]), .state_out(s1)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (mon && o0[13]) mw_seen = 1'b1;
  task automatic add(logic [5:0] op, logic [5:0] fn, logic [3:0] st, logic [16:0] o);
    tbl.push_back('{op, fn, st, o});
  endtask
  task automatic chk(string nm, logic [3:0] st, logic [16:0] o, logic [3:0] es, logic [16:0] eo);
    tests++;
    if (st !== es) begin
      fails++;
      $display("FAIL %s state got %0d expected %0d", nm, st, es);
    end
    tests++;
    if (o !== eo) begin
      fails++;
      $display("FAIL %s outputs got %b expected %b", nm, o, eo);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    add(6'h00, 6'h20, 1, F1);
    add(6'h00, 6'h20, 2, DEC); add(6'h00, 6'h20, 7, ex_r(3'b001));
    add(6'h00, 6'h20, 8, r_wb(3'b001)); add(6'h00, 6'h20, 1, F1);
    add(6'h00, 6'h22, 2, DEC); add(6'h00, 6'h22, 7, ex_r(3'b010));
    add(6'h00, 6'h22, 8, r_wb(3'b010)); add(6'h00, 6'h22, 1, F1);
    add(6'h00, 6'h24, 2, DEC); add(6'h00, 6'h24, 7, ex_r(3'b011));
    add(6'h00, 6'h24, 8, r_wb(3'b011)); add(6'h00, 6'h24, 1, F1);
    add(6'h00, 6'h26, 2, DEC); add(6'h00, 6'h26, 7, ex_r(3'b110));
    add(6'h00, 6'h26, 8, r_wb(3'b110)); add(6'h00, 6'h26, 1, F1);
    add(6'h08, 6'h00, 2, DEC); add(6'h08, 6'h00, 10, AE);
    add(6'h08, 6'h00, 11, AW); add(6'h08, 6'h00, 1, F1);
    add(6'h23, 6'h00, 2, DEC); add(6'h23, 6'h00, 3, MA); add(6'h23, 6'h00, 4, MR);
    add(6'h23, 6'h00, 5, MWB); add(6'h23, 6'h00, 1, F1);
    add(6'h2B, 6'h00, 2, DEC); add(6'h2B, 6'h00, 3, MA);
    add(6'h2B, 6'h00, 6, MWR); add(6'h2B, 6'h00, 1, F1);
    add(6'h04, 6'h00, 2, DEC); add(6'h04, 6'h00, 9, BR); add(6'h04, 6'h00, 1, F1);
    add(6'h02, 6'h00, 2, DEC); add(6'h02, 6'h00, 12, JP); add(6'h02, 6'h00, 1, F1);
    add(6'h3F, 6'h00, 2, DEC); add(6'h3F, 6'h00, 13, EXC); add(6'h3F, 6'h00, 1, F1);
    add(6'h00, 6'h2A, 2, DEC); add(6'h00, 6'h2A, 7, ex_r(3'b000));
    add(6'h00, 6'h2A, 13, EXC); add(6'h00, 6'h2A, 1, F1);
    foreach (tbl[i]) tbl2.push_back(tbl[i]);
    tbl2.delete();
    tbl2.push_back('{6'h23, 6'h00, 4'd1, F0}); tbl2.push_back('{6'h23, 6'h00, 4'd1, F0});
    tbl2.push_back('{6'h23, 6'h00, 4'd1, F1}); tbl2.push_back('{6'h23, 6'h00, 4'd2, DEC});
    tbl2.push_back('{6'h23, 6'h00, 4'd3, MA}); tbl2.push_back('{6'h23, 6'h00, 4'd4, MR});
    tbl2.push_back('{6'h23, 6'h00, 4'd4, MR}); tbl2.push_back('{6'h23, 6'h00, 4'd4, MR});
    tbl2.push_back('{6'h23, 6'h00, 4'd5, MWB}); tbl2.push_back('{6'h23, 6'h00, 4'd1, F0});
    #1 reset = 1'b1;
    #1 chk("reset_async", s0, o0, 4'd0, Z);
    @(posedge clk);
    #1 chk("reset_held", s0, o0, 4'd0, Z);
    #2 reset = 1'b0;
    foreach (tbl[i]) begin
      opcode = tbl[i].op;
      funct  = tbl[i].fn;
      step();
      chk($sformatf("vec%0d", i), s0, o0, tbl[i].st, tbl[i].o);
    end
    opcode = 6'h2B;
    funct  = 6'h00;
    mon    = 1'b1;
    step(); chk("sw_dec", s0, o0, 4'd2, DEC);
    step(); chk("sw_maddr", s0, o0, 4'd3, MA);
    #2 reset = 1'b1;
    #1 chk("sw_reset_async", s0, o0, 4'd0, Z);
    step(); chk("sw_reset_hold", s0, o0, 4'd0, Z);
    #3 reset = 1'b0;
    step(); chk("sw_first_fetch", s0, o0, 4'd1, F1);
    step(); chk("sw_restart_dec", s0, o0, 4'd2, DEC);
    mon = 1'b0;
    tests++;
    if (mw_seen !== 1'b0) begin
      fails++;
      $display("FAIL sw_abort mem_wr got %b expected 0", mw_seen);
    end
    #2 reset = 1'b1;
    #1 chk("mw2_reset", s1, o1, 4'd0, Z);
    step();
    #3 reset = 1'b0;
    rw_cnt = 0;
    foreach (tbl2[i]) begin
      opcode = tbl2[i].op;
      funct  = tbl2[i].fn;
      step();
      if (o1[11]) rw_cnt++;
      chk($sformatf("mw2_vec%0d", i), s1, o1, tbl2[i].st, tbl2[i].o);
    end
    tests++;
    if (rw_cnt != 1) begin
      fails++;
      $display("FAIL mw2_reg_write_count got %0d expected 1", rw_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
